// File: rtl/bfu_pipe_pkg.sv
// Shared constants, mode encodings and a single-step modular correction
// for the q = 12289 butterfly datapath.
package bfu_pipe_pkg;

  localparam int DATA_WIDTH = 14;
  localparam int Q          = 12289;
  localparam int BARRETT_K  = 28;
  localparam int BARRETT_M  = 21843;
  localparam int LATENCY    = 7;
  localparam int MUL_STAGES = 5;

  localparam logic [DATA_WIDTH:0] Q_EXT = (DATA_WIDTH+1)'(Q);

  typedef enum logic {
    MODE_CT = 1'b0,
    MODE_GS = 1'b1
  } mode_e;

  typedef logic [DATA_WIDTH-1:0] coef_t;

  // Brings a value in [0, 2Q) back into [0, Q).
  function automatic coef_t reduce_once(input logic [DATA_WIDTH:0] v);
    logic [DATA_WIDTH:0] sub;
    sub = v - Q_EXT;
    if (v >= Q_EXT) return sub[DATA_WIDTH-1:0];
    else            return v[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/bfu_pipe_if.sv
// Butterfly operand/result bundle; master drives operands, slave is the unit.
interface bfu_pipe_if;
  import bfu_pipe_pkg::*;

  logic  in_valid;
  mode_e mode;
  coef_t a_in;
  coef_t b_in;
  coef_t w_in;
  logic  out_valid;
  coef_t a_out;
  coef_t b_out;

  modport master (output in_valid, mode, a_in, b_in, w_in,
                  input  out_valid, a_out, b_out);
  modport slave  (input  in_valid, mode, a_in, b_in, w_in,
                  output out_valid, a_out, b_out);
endinterface

// File: rtl/bfu_pipe_mod_mul_barrett.sv
// Five-stage pipelined x*y mod Q using Barrett reduction; carries no valid
// so it can be reused wherever a fixed-latency modular product is needed.
module mod_mul_barrett
  import bfu_pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  coef_t x,
  input  coef_t y,
  output coef_t r
);

  localparam int ZW = 2 * DATA_WIDTH;
  localparam int PW = ZW + 15;

  logic [ZW-1:0]       z1, z2, z3, tq3;
  logic [DATA_WIDTH:0] t2, r4;
  coef_t               r5;

  logic [DATA_WIDTH:0] t_next;
  logic [DATA_WIDTH:0] r_next;

  // Quotient estimate is never larger than the true quotient, so z - t*Q lands in [0, 2Q).
  assign t_next = (DATA_WIDTH+1)'((PW'(z1) * PW'(BARRETT_M)) >> BARRETT_K);
  assign r_next = (DATA_WIDTH+1)'(z3 - tq3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z1  <= '0;
      z2  <= '0;
      t2  <= '0;
      z3  <= '0;
      tq3 <= '0;
      r4  <= '0;
      r5  <= '0;
    end else begin
      z1  <= ZW'(x) * ZW'(y);
      z2  <= z1;
      t2  <= t_next;
      z3  <= z2;
      tq3 <= ZW'(t2) * ZW'(Q);
      r4  <= r_next;
      r5  <= reduce_once(r4);
    end
  end

  assign r = r5;

endmodule

// File: rtl/bfu_pipe.sv
// Radix-2 CT/GS modular butterfly, one per cycle, fixed 7-cycle latency;
// S1 pre-add/sub, 5-stage modular multiply, S7 post-add/sub.
module bfu_pipe
  import bfu_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  bfu_pipe_if.slave  bus
);

  localparam int DLY = MUL_STAGES + 1;

  logic [DATA_WIDTH:0] gs_sum, gs_diff, ct_sum, ct_diff;

  coef_t s1_x, s1_w, m;
  coef_t pass_q [DLY];
  mode_e mode_q [DLY];
  logic  valid_q [DLY];

  logic  out_valid_r;
  coef_t a_out_r, b_out_r;

  assign gs_sum  = {1'b0, bus.a_in} + {1'b0, bus.b_in};
  assign gs_diff = {1'b0, bus.a_in} + Q_EXT - {1'b0, bus.b_in};

  // S1 captures operands; in GS mode the multiplier takes the difference and the sum rides along.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_x <= '0;
      s1_w <= '0;
      for (int i = 0; i < DLY; i++) begin
        pass_q[i]  <= '0;
        mode_q[i]  <= MODE_CT;
        valid_q[i] <= 1'b0;
      end
    end else begin
      s1_w       <= bus.w_in;
      mode_q[0]  <= bus.mode;
      valid_q[0] <= bus.in_valid;
      if (bus.mode == MODE_CT) begin
        s1_x      <= bus.b_in;
        pass_q[0] <= bus.a_in;
      end else begin
        s1_x      <= reduce_once(gs_diff);
        pass_q[0] <= reduce_once(gs_sum);
      end
      for (int i = 1; i < DLY; i++) begin
        pass_q[i]  <= pass_q[i-1];
        mode_q[i]  <= mode_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  mod_mul_barrett u_mul (
    .clk (clk),
    .rst (rst),
    .x   (s1_x),
    .y   (s1_w),
    .r   (m)
  );

  assign ct_sum  = {1'b0, pass_q[DLY-1]} + {1'b0, m};
  assign ct_diff = {1'b0, pass_q[DLY-1]} + Q_EXT - {1'b0, m};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      a_out_r     <= '0;
      b_out_r     <= '0;
    end else begin
      out_valid_r <= valid_q[DLY-1];
      if (mode_q[DLY-1] == MODE_CT) begin
        a_out_r <= reduce_once(ct_sum);
        b_out_r <= reduce_once(ct_diff);
      end else begin
        a_out_r <= pass_q[DLY-1];
        b_out_r <= m;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.a_out     = a_out_r;
  assign bus.b_out     = b_out_r;

endmodule

// File: tb/tb_bfu_pipe.sv
// Scoreboard bench for bfu_pipe: every driven cycle pushes its reference result,
// the entry popped after each edge is what the unit must be presenting.
module tb_bfu_pipe;
  import bfu_pipe_pkg::*;

  typedef struct packed {
    logic  v;
    coef_t a;
    coef_t b;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  bfu_pipe_if bus ();

  bfu_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  exp_t sb [$];

  function automatic exp_t model(input logic v, input mode_e md,
                                 input coef_t a, input coef_t b, input coef_t w);
    exp_t   e;
    longint la, lb, lw, lm;
    la = longint'(a);
    lb = longint'(b);
    lw = longint'(w);
    e  = '0;
    e.v = v;
    if (!v) return e;
    if (md == MODE_CT) begin
      lm  = (lw * lb) % Q;
      e.a = coef_t'((la + lm) % Q);
      e.b = coef_t'((la - lm + Q) % Q);
    end else begin
      e.a = coef_t'((la + lb) % Q);
      e.b = coef_t'((((la - lb + Q) % Q) * lw) % Q);
    end
    return e;
  endfunction

  // Empty pipeline: six invalid slots so the first sample pops after its 7th edge.
  task automatic sb_flush();
    sb.delete();
    repeat (LATENCY - 1) sb.push_back('0);
  endtask

  task automatic drive_cycle(input logic v, input mode_e md, input coef_t a,
                             input coef_t b, input coef_t w, output exp_t due);
    bus.in_valid = v;
    bus.mode     = md;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.w_in     = w;
    sb.push_back(model(v, md, a, b, w));
    @(posedge clk);
    #1;
    due = sb.pop_front();
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.mode     = MODE_CT;
    bus.a_in     = 14'd1;
    bus.b_in     = 14'd1;
    bus.w_in     = 14'd1;
    #1;
    n_compared += 3;
    if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset out_valid: got %b want 0", bus.out_valid); end
    if (bus.a_out !== '0) begin n_mismatched++; $display("[TB] FAIL reset a_out: got %0d want 0", bus.a_out); end
    if (bus.b_out !== '0) begin n_mismatched++; $display("[TB] FAIL reset b_out: got %0d want 0", bus.b_out); end
    @(posedge clk);
    #1;
    n_compared++;
    if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_hold out_valid: got %b want 0", bus.out_valid); end
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    sb_flush();
  endtask

  task automatic test_directed();
    mode_e md [4]  = '{MODE_CT, MODE_CT, MODE_CT, MODE_GS};
    coef_t av [4]  = '{14'd1, 14'd0,     14'd12288, 14'd5};
    coef_t bv [4]  = '{14'd1, 14'd12288, 14'd12288, 14'd7};
    coef_t wv [4]  = '{14'd1, 14'd12288, 14'd12288, 14'd2};
    exp_t  due;
    for (int i = 0; i < 4 + LATENCY; i++) begin
      if (i < 4) drive_cycle(1'b1, md[i], av[i], bv[i], wv[i], due);
      else       drive_cycle(1'b0, MODE_CT, '0, '0, '0, due);
      n_compared++;
      if (bus.out_valid !== due.v) begin
        n_mismatched++;
        $display("[TB] FAIL directed out_valid cyc %0d: got %b want %b", i, bus.out_valid, due.v);
      end
      if (due.v) begin
        n_compared += 2;
        if (bus.a_out !== due.a) begin n_mismatched++; $display("[TB] FAIL directed a_out cyc %0d: got %0d want %0d", i, bus.a_out, due.a); end
        if (bus.b_out !== due.b) begin n_mismatched++; $display("[TB] FAIL directed b_out cyc %0d: got %0d want %0d", i, bus.b_out, due.b); end
      end
    end
  endtask

  task automatic test_gap_pattern();
    logic  vp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    mode_e mp [4] = '{MODE_CT, MODE_CT, MODE_GS, MODE_CT};
    exp_t  due;
    for (int i = 0; i < 4 + LATENCY; i++) begin
      if (i < 4)
        drive_cycle(vp[i], mp[i], coef_t'($urandom_range(Q-1, 0)),
                    coef_t'($urandom_range(Q-1, 0)), coef_t'($urandom_range(Q-1, 0)), due);
      else
        drive_cycle(1'b0, MODE_GS, '0, '0, '0, due);
      n_compared++;
      if (bus.out_valid !== due.v) begin
        n_mismatched++;
        $display("[TB] FAIL gap out_valid cyc %0d: got %b want %b", i, bus.out_valid, due.v);
      end
      if (due.v) begin
        n_compared += 2;
        if (bus.a_out !== due.a) begin n_mismatched++; $display("[TB] FAIL gap a_out cyc %0d: got %0d want %0d", i, bus.a_out, due.a); end
        if (bus.b_out !== due.b) begin n_mismatched++; $display("[TB] FAIL gap b_out cyc %0d: got %0d want %0d", i, bus.b_out, due.b); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t due;
    for (int i = 0; i < 10000 + LATENCY; i++) begin
      if (i < 10000)
        drive_cycle(1'b1, mode_e'($urandom_range(1, 0)), coef_t'($urandom_range(Q-1, 0)),
                    coef_t'($urandom_range(Q-1, 0)), coef_t'($urandom_range(Q-1, 0)), due);
      else
        drive_cycle(1'b0, MODE_CT, '0, '0, '0, due);
      n_compared++;
      if (bus.out_valid !== due.v) begin
        n_mismatched++;
        $display("[TB] FAIL b2b out_valid cyc %0d: got %b want %b", i, bus.out_valid, due.v);
      end
      if (due.v) begin
        n_compared += 2;
        if (bus.a_out !== due.a) begin n_mismatched++; $display("[TB] FAIL b2b a_out cyc %0d: got %0d want %0d", i, bus.a_out, due.a); end
        if (bus.b_out !== due.b) begin n_mismatched++; $display("[TB] FAIL b2b b_out cyc %0d: got %0d want %0d", i, bus.b_out, due.b); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    exp_t due;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, mode_e'($urandom_range(1, 0)), coef_t'($urandom_range(Q-1, 0)),
                  coef_t'($urandom_range(Q-1, 0)), coef_t'($urandom_range(Q-1, 0)), due);
      n_compared++;
      if (bus.out_valid !== due.v) begin
        n_mismatched++;
        $display("[TB] FAIL pre_rst out_valid cyc %0d: got %b want %b", i, bus.out_valid, due.v);
      end
      if (due.v) begin
        n_compared += 2;
        if (bus.a_out !== due.a) begin n_mismatched++; $display("[TB] FAIL pre_rst a_out cyc %0d: got %0d want %0d", i, bus.a_out, due.a); end
        if (bus.b_out !== due.b) begin n_mismatched++; $display("[TB] FAIL pre_rst b_out cyc %0d: got %0d want %0d", i, bus.b_out, due.b); end
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_compared += 3;
    if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_rst out_valid: got %b want 0", bus.out_valid); end
    if (bus.a_out !== '0) begin n_mismatched++; $display("[TB] FAIL async_rst a_out: got %0d want 0", bus.a_out); end
    if (bus.b_out !== '0) begin n_mismatched++; $display("[TB] FAIL async_rst b_out: got %0d want 0", bus.b_out); end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    sb_flush();
    for (int i = 0; i < 10 + 1 + LATENCY; i++) begin
      if (i == 10)
        drive_cycle(1'b1, MODE_GS, coef_t'($urandom_range(Q-1, 0)),
                    coef_t'($urandom_range(Q-1, 0)), coef_t'($urandom_range(Q-1, 0)), due);
      else
        drive_cycle(1'b0, MODE_CT, '0, '0, '0, due);
      n_compared++;
      if (bus.out_valid !== due.v) begin
        n_mismatched++;
        $display("[TB] FAIL post_rst out_valid cyc %0d: got %b want %b", i, bus.out_valid, due.v);
      end
      if (due.v) begin
        n_compared += 2;
        if (bus.a_out !== due.a) begin n_mismatched++; $display("[TB] FAIL post_rst a_out cyc %0d: got %0d want %0d", i, bus.a_out, due.a); end
        if (bus.b_out !== due.b) begin n_mismatched++; $display("[TB] FAIL post_rst b_out cyc %0d: got %0d want %0d", i, bus.b_out, due.b); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gap_pattern();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
